// File: rtl/branch_flow_unit.sv
// ----------------------------------------------------------------------------
// branch_flow_unit
//
// Purpose:
//   Sequential side of the fetch-path branch logic. It keeps the registered
//   Z/N flags that the branch decision reads and the program counter. It also
//   squashes wrong-path fetches for a fixed window after a taken branch, and
//   it supports stall and halt.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   ALUResult      execute-stage result, used to form Z/N
//   FlagWrite      capture Z/N from ALUResult at this edge
//   PCSource       branch taken (computed from the current FlagZ/FlagN)
//   BranchTarget   new PC when a branch is accepted
//   Stall          hold PC, flags and flush counter
//   Halt           enter HALTED (exit only by reset)
//   FlagZ, FlagN   registered flags
//   PC             current fetch address
//   FlushIF/ID     squash IF/ID while the wrong-path window is open
//   Halted         high in HALTED
//   DbgState       current FSM state (0 RUN, 1 FLUSH, 2 HALTED)
//   BranchCount    accepted taken-branch count, saturating (only with
//                  BRANCH_COUNT_EN defined)
//
// Configuration macro: BRANCH_COUNT_EN
//
// Handshake: there is no valid/ready handshake. Every input is sampled at
//   every rising edge. PCSource is only acted on in RUN with Stall=0 and
//   Halt=0.
// ----------------------------------------------------------------------------
module branch_flow_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter int               PC_STEP      = 4,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             FlagWrite,
    input  logic             PCSource,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Stall,
    input  logic             Halt,
`ifdef BRANCH_COUNT_EN
    output logic [15:0]      BranchCount,
`endif
    output logic [1:0]       DbgState,
    output logic             FlagZ,
    output logic             FlagN,
    output logic [WIDTH-1:0] PC,
    output logic             FlushIF,
    output logic             FlushID,
    output logic             Halted
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FLUSH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_next_pc;
    logic [3:0]       r_cnt;
    logic [3:0]       w_next_cnt;
    logic             r_flag_z;
    logic             r_flag_n;
    logic             w_flag_we;
    logic             w_branch_taken;

    // Next-state, next-PC and flush-counter logic
    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_next_cnt     = r_cnt;
        w_branch_taken = 1'b0;
        case (r_state)
            S_RUN: begin
                if (Halt) begin
                    w_next_state = S_HALTED;
                end else if (!Stall) begin
                    if (PCSource) begin
                        w_next_pc      = BranchTarget;
                        w_next_cnt     = FLUSH_INIT;
                        w_next_state   = S_FLUSH;
                        w_branch_taken = 1'b1;
                    end else begin
                        w_next_pc = r_pc + STEP;
                    end
                end
            end
            S_FLUSH: begin
                // PCSource is ignored here: anything it reports comes from
                // a wrong-path instruction.
                if (Halt) begin
                    w_next_state = S_HALTED;
                end else if (!Stall) begin
                    w_next_pc  = r_pc + STEP;
                    w_next_cnt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_next_state = S_RUN;
                    end
                end
            end
            S_HALTED: begin
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // Flags freeze in HALTED and when stalled.
    assign w_flag_we = FlagWrite && !Stall && (r_state != S_HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_cnt    <= 4'd0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_cnt   <= w_next_cnt;
            if (w_flag_we) begin
                r_flag_z <= (ALUResult == '0);
                r_flag_n <= ALUResult[WIDTH-1];
            end
        end
    end

`ifdef BRANCH_COUNT_EN
    logic [15:0] r_branch_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count <= 16'd0;
        end else if (w_branch_taken && (r_branch_count != 16'hFFFF)) begin
            r_branch_count <= r_branch_count + 16'd1;
        end
    end

    assign BranchCount = r_branch_count;
`else
    logic w_unused_branch;
    assign w_unused_branch = w_branch_taken;
`endif

    assign PC       = r_pc;
    assign FlagZ    = r_flag_z;
    assign FlagN    = r_flag_n;
    assign FlushIF  = (r_state == S_FLUSH);
    assign FlushID  = (r_state == S_FLUSH);
    assign Halted   = (r_state == S_HALTED);
    assign DbgState = r_state;

endmodule
